// File: rtl/bf16_pkg.sv
// bf16_pkg: shared bfloat16 constants, opcodes and unpacked-operand type for bf16_fpu.
package bf16_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 7;
  localparam int BIAS = 127;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [15:0] POS_INF = 16'h7F80;
  localparam logic [15:0] NEG_INF = 16'hFF80;
  localparam logic [15:0] QNAN = 16'h7FC0;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W:0] mant;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } bf16_unp_t;
  // Subnormals flush to zero: any exp of 0 counts as a zero operand.
  function automatic bf16_unp_t unpack(input logic [15:0] w);
    bf16_unp_t u;
    u.sign = w[15];
    u.exp = w[14:7];
    u.mant = {1'b1, w[6:0]};
    u.is_zero = w[14:7] == 8'h00;
    u.is_inf = w[14:7] == 8'hFF && w[6:0] == 7'd0;
    u.is_nan = w[14:7] == 8'hFF && w[6:0] != 7'd0;
    return u;
  endfunction
endpackage

// File: rtl/bf16_round_pack.sv
// bf16_round_pack: RNE rounding, renormalization and overflow/underflow packing of a bf16 result.
module bf16_round_pack
  import bf16_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [10:0] exp_i,
  input  logic [7:0]         mant_i,
  input  logic               guard_i,
  input  logic               round_i,
  input  logic               sticky_i,
  output logic [15:0]        res_o,
  output logic               ovf_o
);
  logic inc;
  logic [8:0] sum;
  logic signed [10:0] be;
  always_comb begin
    inc = guard_i & (round_i | sticky_i | mant_i[0]);
    sum = {1'b0, mant_i} + {8'd0, inc};
    be = exp_i + 11'(BIAS) + $signed({10'd0, sum[8]});
    ovf_o = be >= 11'sd255;
    res_o = ovf_o ? {sign_i, POS_INF[14:0]} : (be <= 11'sd0) ? {sign_i, 15'd0} : {sign_i, be[7:0], sum[6:0]};
  end
endmodule

// File: rtl/bf16_fpu.sv
// bf16_fpu: combinational bf16 ADD/SUB/MUL/DIV with sticky overflow flag.
// Define FPU_OUT_REG_EN to register out_o/overflow_o (1-cycle latency).
module bf16_fpu
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_i,
  input  logic [15:0] in1_i,
  input  logic [15:0] in2_i,
  output logic [15:0] out_o,
  output logic        overflow_o,
  output logic        ovf_sticky_o
);
  bf16_unp_t a, b;
  logic sb_eff, swap, s_big, s_small, sp, sp_ovf, rp_sign, rp_g, rp_r, rp_s, rp_ovf, ovf, sticky_q, sticky_d;
  logic [7:0] ex_b, ex_s, m_b, m_s, d, rp_mant;
  logic [18:0] wide;
  logic [10:0] sm_x, q;
  logic [11:0] sum, norm;
  logic [3:0] p;
  logic [15:0] prod, sp_res, rp_res, res;
  logic [8:0] rem;
  logic signed [10:0] add_exp, mul_exp, div_exp, rp_exp;
  assign a = unpack(in1_i);
  assign b = unpack(in2_i);
  always_comb begin
    sb_eff = b.sign ^ (op_i == OP_SUB);
    swap = {b.exp, b.mant} > {a.exp, a.mant};
    ex_b = swap ? b.exp : a.exp;
    ex_s = swap ? a.exp : b.exp;
    m_b = swap ? b.mant : a.mant;
    m_s = swap ? a.mant : b.mant;
    s_big = swap ? sb_eff : a.sign;
    s_small = swap ? a.sign : sb_eff;
    d = ex_b - ex_s;
    wide = {m_s, 11'd0} >> d;
    sm_x = d >= 8'd11 ? 11'd1 : {wide[18:9], |wide[8:0]};
    sum = (s_big == s_small) ? {1'b0, m_b, 3'b000} + {1'b0, sm_x} : {1'b0, m_b, 3'b000} - {1'b0, sm_x};
    p = 4'd0;
    for (int i = 0; i < 12; i++) if (sum[i]) p = 4'(i);
    norm = sum << (4'd11 - p);
    add_exp = $signed({3'b000, ex_b}) - 11'(BIAS) + $signed({7'd0, p}) - 11'sd10;
  end
  always_comb begin
    prod = a.mant * b.mant;
    mul_exp = $signed({3'b000, a.exp}) + $signed({3'b000, b.exp}) - 11'sd254 + $signed({10'd0, prod[15]});
  end
  // Restoring division; the quotient's top bit is set iff mant A >= mant B.
  always_comb begin
    rem = {1'b0, a.mant};
    q = 11'd0;
    for (int i = 10; i >= 0; i--) begin
      if (rem >= {1'b0, b.mant}) begin
        rem = rem - {1'b0, b.mant};
        q[i] = 1'b1;
      end
      rem = rem << 1;
    end
    div_exp = $signed({3'b000, a.exp}) - $signed({3'b000, b.exp}) - $signed({10'd0, ~q[10]});
  end
  always_comb begin
    sp = 1'b1;
    sp_res = 16'h0000;
    sp_ovf = 1'b0;
    rp_sign = 1'b0;
    rp_exp = 11'sd0;
    rp_mant = 8'd0;
    rp_g = 1'b0;
    rp_r = 1'b0;
    rp_s = 1'b0;
    if (!(op_i == OP_ADD || op_i == OP_SUB || op_i == OP_MUL || op_i == OP_DIV)) sp_res = 16'h0000;
    else if (a.is_nan || b.is_nan) sp_res = QNAN;
    else if (op_i == OP_MUL) begin
      if ((a.is_zero && b.is_inf) || (a.is_inf && b.is_zero)) sp_res = QNAN;
      else if (a.is_inf || b.is_inf) sp_res = {a.sign ^ b.sign, POS_INF[14:0]};
      else if (a.is_zero || b.is_zero) sp_res = {a.sign ^ b.sign, 15'd0};
      else begin
        sp = 1'b0;
        rp_sign = a.sign ^ b.sign;
        rp_exp = mul_exp;
        rp_mant = prod[15] ? prod[15:8] : prod[14:7];
        rp_g = prod[15] ? prod[7] : prod[6];
        rp_r = prod[15] ? prod[6] : prod[5];
        rp_s = prod[15] ? |prod[5:0] : |prod[4:0];
      end
    end else if (op_i == OP_DIV) begin
      if ((a.is_inf && b.is_inf) || (a.is_zero && b.is_zero)) sp_res = QNAN;
      else if (a.is_inf) sp_res = {a.sign ^ b.sign, POS_INF[14:0]};
      else if (b.is_inf || a.is_zero) sp_res = {a.sign ^ b.sign, 15'd0};
      else if (b.is_zero) begin
        sp_res = {a.sign ^ b.sign, POS_INF[14:0]};
        sp_ovf = 1'b1;
      end else begin
        sp = 1'b0;
        rp_sign = a.sign ^ b.sign;
        rp_exp = div_exp;
        rp_mant = q[10] ? q[10:3] : q[9:2];
        rp_g = q[10] ? q[2] : q[1];
        rp_r = q[10] ? q[1] : q[0];
        rp_s = (q[10] & q[0]) | (rem != 9'd0);
      end
    end else begin
      if (a.is_inf && b.is_inf && a.sign != sb_eff) sp_res = QNAN;
      else if (a.is_inf) sp_res = {a.sign, POS_INF[14:0]};
      else if (b.is_inf) sp_res = {sb_eff, POS_INF[14:0]};
      else if (a.is_zero && b.is_zero) sp_res = {a.sign & sb_eff, 15'd0};
      else if (a.is_zero) sp_res = {sb_eff, in2_i[14:0]};
      else if (b.is_zero) sp_res = in1_i;
      else if (sum == 12'd0) sp_res = 16'h0000;
      else begin
        sp = 1'b0;
        rp_sign = s_big;
        rp_exp = add_exp;
        rp_mant = norm[11:4];
        rp_g = norm[3];
        rp_r = norm[2];
        rp_s = |norm[1:0];
      end
    end
  end
  bf16_round_pack u_rp (
    .sign_i(rp_sign), .exp_i(rp_exp), .mant_i(rp_mant),
    .guard_i(rp_g), .round_i(rp_r), .sticky_i(rp_s),
    .res_o(rp_res), .ovf_o(rp_ovf)
  );
  assign res = sp ? sp_res : rp_res;
  assign ovf = sp ? sp_ovf : rp_ovf;
`ifdef FPU_OUT_REG_EN
  logic [15:0] out_q;
  logic ovf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_q <= 16'h0000;
      ovf_q <= 1'b0;
    end else begin
      out_q <= res;
      ovf_q <= ovf;
    end
  assign out_o = out_q;
  assign overflow_o = ovf_q;
  assign sticky_d = sticky_q | ovf_q;
`else
  assign out_o = res;
  assign overflow_o = ovf;
  assign sticky_d = sticky_q | ovf;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  assign ovf_sticky_o = sticky_q;
endmodule

// File: tb/tb_bf16_fpu.sv
// tb_bf16_fpu: directed golden-vector bench for bf16_fpu (both FPU_OUT_REG_EN builds).
module tb_bf16_fpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] op_i = 4'd0;
  logic [15:0] in1_i = 16'd0, in2_i = 16'd0, out_o;
  logic overflow_o, ovf_sticky_o;
  int n_tests = 0, n_fail = 0;
  bf16_fpu dut (
    .clk(clk), .rst(rst), .op_i(op_i), .in1_i(in1_i), .in2_i(in2_i),
    .out_o(out_o), .overflow_o(overflow_o), .ovf_sticky_o(ovf_sticky_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic vec(input string tag, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] r, input logic v);
    @(negedge clk);
    op_i = op;
    in1_i = x;
    in2_i = y;
`ifdef FPU_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
    chk({tag, "_out"}, out_o, r);
    chk({tag, "_ovf"}, {15'd0, overflow_o}, {15'd0, v});
  endtask
  initial begin
    #12;
    chk("rst_sticky", {15'd0, ovf_sticky_o}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    vec("add_1_2", 4'b0001, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    vec("sub_1_2", 4'b0010, 16'h3F80, 16'h4000, 16'hBF80, 1'b0);
    vec("mul_2_3", 4'b0100, 16'h4000, 16'h4040, 16'h40C0, 1'b0);
    vec("mul_n2_3", 4'b0100, 16'hC000, 16'h4040, 16'hC0C0, 1'b0);
    vec("div_3_2", 4'b1000, 16'h4040, 16'h4000, 16'h3FC0, 1'b0);
    vec("div_1_3", 4'b1000, 16'h3F80, 16'h4040, 16'h3EAB, 1'b0);
    vec("mul_zero", 4'b0100, 16'h3F80, 16'h0000, 16'h0000, 1'b0);
    vec("rne_tie_even", 4'b0001, 16'h3F80, 16'h3B80, 16'h3F80, 1'b0);
    vec("rne_tie_odd", 4'b0001, 16'h3F81, 16'h3B80, 16'h3F82, 1'b0);
    vec("cancel", 4'b0010, 16'h4040, 16'h4040, 16'h0000, 1'b0);
    vec("underflow", 4'b0100, 16'h0080, 16'h3F00, 16'h0000, 1'b0);
    vec("inf_plus_1", 4'b0001, 16'h7F80, 16'h3F80, 16'h7F80, 1'b0);
    vec("div_by_inf", 4'b1000, 16'h4000, 16'h7F80, 16'h0000, 1'b0);
    vec("inf_m_inf", 4'b0001, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0);
    vec("nan_in", 4'b0100, 16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0);
    vec("bad_op", 4'b0011, 16'h3F80, 16'h4000, 16'h0000, 1'b0);
    chk("sticky_clear", {15'd0, ovf_sticky_o}, 16'd0);
    vec("mul_ovf", 4'b0100, 16'h7F7F, 16'h4000, 16'h7F80, 1'b1);
    @(posedge clk);
    #1;
    chk("sticky_set", {15'd0, ovf_sticky_o}, 16'd1);
    vec("div_by_0", 4'b1000, 16'h3F80, 16'h0000, 16'h7F80, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", {15'd0, ovf_sticky_o}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bf16_fpu.md
Name: bf16_fpu

Overview:
- Single-operation bfloat16 arithmetic unit: ADD, SUB, MUL or DIV on two bf16 operands, selected by a one-hot opcode.
- Datapath is combinational: the result is valid in the same cycle the inputs and opcode are applied.
- The only clocked state is a sticky overflow flag (and the optional output register).
- Sits as a leaf arithmetic block; golden-vector benches compare out_o bit-exactly.

Parameters:
- None. Format fixed: bit 15 sign, bits 14:7 exponent (bias 127), bits 6:0 fraction.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all registers.
- op_i  input  4  one-hot op: 4'b0001 ADD, 4'b0010 SUB, 4'b0100 MUL, 4'b1000 DIV.
- in1_i  input  16  operand A (bf16).
- in2_i  input  16  operand B (bf16).
- out_o  output  16  result (bf16).
- overflow_o  output  1  result overflowed to infinity this operation.
- ovf_sticky_o  output  1  latched OR of overflow_o since reset.

Behaviour:
- ADD: A+B. SUB: A−B, implemented as ADD with B sign inverted. MUL: A×B. DIV: A÷B.
- Zero latency: out_o and overflow_o are pure functions of op_i, in1_i and in2_i. No dependence on clk.
- Rounding: round-to-nearest, ties-to-even.
  - Keep guard, round and sticky bits through alignment and normalization.
  - Rounding carry renormalizes, incrementing the exponent.
- Subnormals: flush-to-zero on inputs (exp=0 is treated as ±0) and on outputs (underflow gives ±0, overflow_o=0).
- Overflow: if the rounded exponent is ≥255, out_o = ±inf (0x7F80/0xFF80) and overflow_o=1.
- Infinity inputs:
  - Inf arithmetic per IEEE with overflow_o=0 (e.g. inf+1 = inf).
  - inf−inf, 0×inf, inf/inf and 0/0 give canonical NaN 0x7FC0, overflow_o=0.
- NaN: any NaN input gives 0x7FC0, overflow_o=0.
- DIV by zero with finite nonzero A: out_o = ±inf (sign = XOR of operand signs), overflow_o=1.
- Signed zero:
  - Exact cancellation in ADD/SUB gives +0 (0x0000).
  - MUL/DIV zero results carry the XOR of operand signs.
- DIV mantissa: combinational restoring division of 1.f_A by 1.f_B, producing 8 quotient bits plus guard, round and sticky (remainder ≠ 0).
- MUL mantissa: 8×8 unsigned multiply, 16-bit product, normalize by at most 1.
- Illegal op_i (not exactly one bit set): out_o=0x0000, overflow_o=0.
- ovf_sticky_o:
  - Set at a rising clk edge when overflow_o=1; holds until rst.
  - rst forces 0 immediately (async). If rst and overflow are simultaneous, rst wins.
- Reset values: ovf_sticky_o=0. out_o and overflow_o are combinational and not reset, except when the optional register is enabled.

Optional Feature:
- Macro FPU_OUT_REG_EN.
- Defined:
  - out_o and overflow_o are registered on the rising clk edge, giving 1-cycle latency.
  - Both reset asynchronously to 0.
  - ovf_sticky_o samples the registered overflow.
- Undefined: combinational outputs with zero latency, as described above.

Decomposition:
- Shared package bf16_pkg holds:
  - Width constants: EXP_W=8, FRAC_W=7, BIAS=127.
  - Opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - Special encodings: POS_INF, NEG_INF, QNAN=0x7FC0.
  - An unpacked-operand struct typedef: sign, exp, mant-with-hidden-bit, is_zero, is_inf, is_nan.
- One natural sub-module: bf16_round_pack.
  - Takes sign, unbiased exponent, mantissa, guard, round and sticky.
  - Applies RNE, renormalizes, and detects overflow/underflow.
  - Emits the bf16 word plus overflow.
  - Shared by all four ops.

Test Plan:
- ADD 0x3F80+0x4000 -> out_o=0x4040 (3.0), overflow_o=0; SUB 0x3F80−0x4000 -> 0xBF80 (−1.0).
- MUL 0x4000×0x4040 -> 0x40C0 (6.0); DIV 0x4040÷0x4000 -> 0x3FC0 (1.5); MUL 0x3F80×0x0000 -> 0x0000.
- RNE tie: ADD 0x3F80+0x3B80 (1+2^-8) -> 0x3F80; ADD 0x3F81+0x3B80 -> 0x3F82; SUB 0x4040−0x4040 -> 0x0000.
- Overflow: MUL 0x7F7F×0x4000 -> 0x7F80, overflow_o=1; DIV 0x3F80÷0x0000 -> 0x7F80, overflow_o=1; next clk edge sets ovf_sticky_o=1.
- Specials: ADD 0x7F80+0xFF80 -> 0x7FC0; MUL 0x7FC1×0x3F80 -> 0x7FC0; op_i=4'b0011 -> 0x0000, overflow_o=0.
- Reset: assert rst mid-cycle with ovf_sticky_o=1 -> ovf_sticky_o drops to 0 without a clock edge. With FPU_OUT_REG_EN, ADD 0x3F80+0x4000 appears on out_o one cycle later.
